// File: rtl/reg_bank_if.sv
// Bus bundle for reg_bank: write port, two read ports and the clear-sweep handshake.
interface reg_bank_if #(
  parameter int M = 32,
  parameter int N = 16
);
  localparam int AW = $clog2(N);

  logic          WE;
  logic [AW-1:0] WA;
  logic [M-1:0]  DATA_IN;
  logic [AW-1:0] RA1;
  logic [AW-1:0] RA2;
  logic [M-1:0]  RD1;
  logic [M-1:0]  RD2;
  logic          CLR;
  logic          BUSY;
  logic          WR_READY;

  modport master (
    output WE, WA, DATA_IN, RA1, RA2, CLR,
    input  RD1, RD2, BUSY, WR_READY
  );

  modport slave (
    input  WE, WA, DATA_IN, RA1, RA2, CLR,
    output RD1, RD2, BUSY, WR_READY
  );
endinterface

// File: rtl/reg_bank.sv
// Register bank with one write port, two combinational read ports and a
// sequential clear sweep that zeroes one register per cycle while BUSY is high.
module reg_bank #(
  parameter int M       = 32,
  parameter int N       = 16,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 0
) (
  input logic       clk,
  input logic       reset,
  reg_bank_if.slave bus
);
  localparam int AW = $clog2(N);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  logic [M-1:0]  mem_q [N];
  logic [M-1:0]  mem_d [N];
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_accept;

  // An address holds real storage if it exists and is not the hardwired zero register.
  function automatic logic live_addr(input logic [AW-1:0] a);
    return (32'(a) < N) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  assign wr_accept    = bus.WE && (state_q == IDLE);
  assign bus.BUSY     = (state_q == SWEEP);
  assign bus.WR_READY = (state_q == IDLE);

  // Read port 1: zero for dead addresses, optional forwarding of an accepted write.
  always_comb begin
    bus.RD1 = '0;
    if (live_addr(bus.RA1)) begin
      if ((BYPASS != 0) && wr_accept && (bus.WA == bus.RA1))
        bus.RD1 = bus.DATA_IN;
      else
        bus.RD1 = mem_q[bus.RA1];
    end
  end

  // Read port 2: identical behaviour to port 1.
  always_comb begin
    bus.RD2 = '0;
    if (live_addr(bus.RA2)) begin
      if ((BYPASS != 0) && wr_accept && (bus.WA == bus.RA2))
        bus.RD2 = bus.DATA_IN;
      else
        bus.RD2 = mem_q[bus.RA2];
    end
  end

  // Next state: writes only in IDLE; SWEEP clears mem[idx] each cycle and ignores CLR/WE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (wr_accept && live_addr(bus.WA))
          mem_d[bus.WA] = bus.DATA_IN;
        if (bus.CLR) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        mem_d[idx_q] = '0;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State registers; reset clears storage and aborts any sweep immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter M, default 32: data width in bits.
REQ-002 Parameter N, default 16: number of registers, N >= 2; AW = $clog2(N).
REQ-003 Parameter ZERO_R0, default 1: 1 = register 0 reads as 0 and ignores writes.
REQ-004 Parameter BYPASS, default 0: 1 = write data is forwarded to read ports in the cycle of the write.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 WE  in  1  write enable, sampled on the rising edge of clk.
REQ-008 WA  in  AW  write address.
REQ-009 DATA_IN  in  M  write data.
REQ-010 RA1  in  AW  read address, port 1.
REQ-011 RA2  in  AW  read address, port 2.
REQ-012 RD1  out  M  read data, port 1, combinational.
REQ-013 RD2  out  M  read data, port 2, combinational.
REQ-014 CLR  in  1  request for a sequential clear sweep, one-cycle pulse.
REQ-015 BUSY  out  1  high while the clear sweep runs.
REQ-016 WR_READY  out  1  high when a write is accepted; equals !BUSY.

Function
REQ-017 Storage SHALL be N registers of M bits; reads are asynchronous: RDx = mem[RAx] in the same cycle.
REQ-018 When WE=1 and WR_READY=1 at a rising edge of clk, mem[WA] SHALL take DATA_IN; the new value is visible on RDx from the next cycle.
REQ-019 With ZERO_R0=1, writes to address 0 SHALL be discarded, and a read of address 0 SHALL return 0.
REQ-020 When N is not a power of two and WA >= N, the write SHALL be discarded; a read with RAx >= N SHALL return 0.
REQ-021 With BYPASS=1, WE=1, WR_READY=1, WA==RAx and WA a writable address, RDx SHALL return DATA_IN combinationally; with BYPASS=0, RDx returns the old value.
REQ-022 FSM states: IDLE and SWEEP.
REQ-023 IDLE -> SWEEP on a rising edge with CLR=1; the sweep index IDX is loaded with 0.
REQ-024 In SWEEP, each rising edge SHALL write 0 to mem[IDX] and increment IDX.
REQ-025 In SWEEP with IDX==N-1, the edge SHALL clear mem[N-1] and return the FSM to IDLE.
REQ-026 A sweep SHALL last exactly N cycles.
REQ-027 BUSY SHALL be 1 exactly in SWEEP.
REQ-028 CLR asserted while in SWEEP SHALL be ignored; it does not restart the sweep.
REQ-029 WE asserted while in SWEEP SHALL be discarded, with no write to any register.
REQ-030 WE=1 and CLR=1 together in IDLE: the write SHALL take effect, then the following sweep clears it.
REQ-031 Reads during SWEEP SHALL return current contents: cleared entries read 0, and uncleared entries keep their old values.

Reset
REQ-032 reset=1 SHALL immediately, without waiting for clk, set all N registers to 0, set the FSM to IDLE, set IDX to 0, set BUSY to 0 and set WR_READY to 1.
REQ-033 reset asserted during a SWEEP SHALL abort the sweep; after release the block is in IDLE with all registers 0.
REQ-034 While reset=1, WE and CLR SHALL be ignored.

Verification
REQ-035 Defaults. Write 0xDEADBEEF to address 5, then next cycle set RA1=5 -> RD1=0xDEADBEEF. Same-cycle read with RA2=5 -> old value, 0.
REQ-036 ZERO_R0=1. Write 0x1234 to address 0 -> RD1 for RA1=0 stays 0x00000000.
REQ-037 Sweep. Fill registers 1..15 with values 0x11 times the index, pulse CLR -> BUSY high for exactly 16 cycles and WR_READY low. After the 3rd sweep edge, RA1=2 reads 0 and RA2=3 reads 0x33. After the sweep, all registers read 0.
REQ-038 Write during sweep. Write 0xAA to address 15 in sweep cycle 16, as the last edge -> discarded, and address 15 reads 0. CLR in sweep cycle 4 -> sweep still ends at cycle 16.
REQ-039 BYPASS=1. Write 0x55 to address 7 with RA1=7 in the same cycle -> RD1=0x55 in that cycle.
REQ-040 Async reset. Assert reset mid-sweep, between clock edges -> BUSY=0 and all RDx=0 immediately. After release, write address 3 -> accepted on the first edge.
